// File: rtl/seg_scan4.sv
// Four-digit multiplexed seven-segment scan driver.
// Keeps the last four distinct counter values and shows the newest on digit 0.
module seg_scan4 #(
    parameter int SCAN_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] din,
    input  logic       hold,
    output logic [6:0] seg,
    output logic [3:0] dig,
    output logic       upd
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [3:0]    din_q;
    logic          armed;
    logic [3:0]    h [4];
    logic [3:0]    v;
    logic [PW-1:0] pcnt;
    logic [1:0]    sel;

    logic          cap;
    logic          tick;
    logic [6:0]    seg_nxt;

    function automatic logic [6:0] hex7(input logic [3:0] x);
        case (x)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    // NOTE: every variable driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        cap     = 1'b0;
        tick    = 1'b0;
        seg_nxt = 7'h00;
        cap     = (!armed || (din != din_q)) && !hold;
        tick    = (pcnt == PW'(SCAN_DIV - 1));
        if (v[sel]) seg_nxt = hex7(h[sel]);
    end

    // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            din_q <= 4'h0;
            armed <= 1'b0;
            v     <= 4'b0000;
            upd   <= 1'b0;
        end else begin
            din_q <= din;
            armed <= 1'b1;
            upd   <= cap;
            if (cap) v <= {v[2:0], 1'b1};
        end
    end

    // NOTE: the history array is reset explicitly so the blank/valid logic never sees X.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) h[i] <= 4'h0;
        end else if (cap) begin
            h[3] <= h[2];
            h[2] <= h[1];
            h[1] <= h[0];
            h[0] <= din;
        end
    end

    // Prescaler, scan index and registered display outputs share one slot timing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt <= '0;
            sel  <= 2'd0;
            seg  <= 7'h00;
            dig  <= 4'b1111;
        end else begin
            pcnt <= tick ? '0 : pcnt + PW'(1);
            if (tick) sel <= sel + 2'd1;
            dig  <= ~(4'b0001 << sel);
            seg  <= seg_nxt;
        end
    end

endmodule
